// File: rtl/gpio_in_conditioner_if.sv
// Pin-side bundle of the GPIO input conditioner: raw pins, edge enables and
// clears in; debounced levels, pending flags and the interrupt line out.
interface gpio_in_conditioner_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] PIN_IN;
  logic [WIDTH-1:0] RISE_EN;
  logic [WIDTH-1:0] FALL_EN;
  logic [WIDTH-1:0] IRQ_CLR;
  logic [WIDTH-1:0] GPIOIN;
  logic [WIDTH-1:0] IRQ_PEND;
  logic             GPIOINT;

  // Driver side: the environment supplying pins and interrupt control.
  modport master (
    output PIN_IN,
    output RISE_EN,
    output FALL_EN,
    output IRQ_CLR,
    input  GPIOIN,
    input  IRQ_PEND,
    input  GPIOINT
  );

  // Conditioner side.
  modport slave (
    input  PIN_IN,
    input  RISE_EN,
    input  FALL_EN,
    input  IRQ_CLR,
    output GPIOIN,
    output IRQ_PEND,
    output GPIOINT
  );
endinterface

// File: rtl/gpio_in_conditioner.sv
// Two-flop synchroniser, per-bit debounce, and sticky edge-pending flags with
// a single OR-reduced interrupt line for the AHB GPIO peripheral's GPIOIN.
module gpio_in_conditioner #(
  parameter int WIDTH     = 16,
  parameter int DB_CYCLES = 4
) (
  input logic                  HCLK,
  input logic                  HRESET,
  gpio_in_conditioner_if.slave bus
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [WIDTH-1:0] gpioin_r;
  logic [WIDTH-1:0] pend_r;
  logic [CNT_W-1:0] cnt_r     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt_s [WIDTH];
  logic [WIDTH-1:0] accept_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] gpioin_nxt_s;
  logic [WIDTH-1:0] pend_nxt_s;

  // Per-bit debounce counters; an accept fires when a differing level has
  // been seen for DB_CYCLES consecutive synchronised cycles.
  always_comb begin
    accept_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      if (sync2_r[i] == gpioin_r[i]) begin
        cnt_nxt_s[i] = CNT_ZERO;
      end else if (cnt_r[i] == CNT_MAX) begin
        accept_s[i]  = 1'b1;
        cnt_nxt_s[i] = CNT_ZERO;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // Edge classification and sticky pending update; a set beats a clear.
  always_comb begin
    rise_s       = accept_s & sync2_r;
    fall_s       = accept_s & ~sync2_r;
    gpioin_nxt_s = (gpioin_r & ~accept_s) | (sync2_r & accept_s);
    pend_nxt_s   = (rise_s & bus.RISE_EN) | (fall_s & bus.FALL_EN)
                 | (pend_r & ~bus.IRQ_CLR);
  end

  // State registers; reset discards any partial debounce count.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sync1_r  <= {WIDTH{1'b0}};
      sync2_r  <= {WIDTH{1'b0}};
      gpioin_r <= {WIDTH{1'b0}};
      pend_r   <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      sync1_r  <= bus.PIN_IN;
      sync2_r  <= sync1_r;
      gpioin_r <= gpioin_nxt_s;
      pend_r   <= pend_nxt_s;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  assign bus.GPIOIN   = gpioin_r;
  assign bus.IRQ_PEND = pend_r;
  assign bus.GPIOINT  = |pend_r;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench for gpio_in_conditioner: expectations are queued with the
// edge at which they must hold and checked by a negedge monitor.
module tb_gpio_in_conditioner;

  logic HCLK = 1'b0;
  logic HRESET;
  int   edge_cnt = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    int          cyc;
    string       tag;
    logic [15:0] gpioin;
    logic [15:0] pend;
    logic        gint;
  } exp_t;

  exp_t sb[$];

  gpio_in_conditioner_if #(.WIDTH(16)) bus ();

  gpio_in_conditioner #(.WIDTH(16), .DB_CYCLES(4)) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) edge_cnt <= edge_cnt + 1;

  // Scoreboard: pop every expectation due at this edge and compare.
  always @(negedge HCLK) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
      e = sb.pop_front();
      total++;
      assert (e.cyc == edge_cnt &&
              {bus.GPIOIN, bus.IRQ_PEND, bus.GPIOINT} === {e.gpioin, e.pend, e.gint})
      else begin
        bad++;
        $error("FAIL %s: got gpioin=%h pend=%h int=%b at edge %0d, want gpioin=%h pend=%h int=%b at edge %0d",
               e.tag, bus.GPIOIN, bus.IRQ_PEND, bus.GPIOINT, edge_cnt,
               e.gpioin, e.pend, e.gint, e.cyc);
      end
    end
  end

  task automatic expect_at(input int n, input string tag, input logic [15:0] g,
                           input logic [15:0] p, input logic i);
    exp_t e;
    e.cyc    = edge_cnt + n;
    e.tag    = tag;
    e.gpioin = g;
    e.pend   = p;
    e.gint   = i;
    sb.push_back(e);
  endtask

  task automatic check_now(input string tag, input logic [15:0] g,
                           input logic [15:0] p, input logic i);
    total++;
    if ({bus.GPIOIN, bus.IRQ_PEND, bus.GPIOINT} !== {g, p, i}) begin
      bad++;
      $error("FAIL %s: got gpioin=%h pend=%h int=%b, want gpioin=%h pend=%h int=%b",
             tag, bus.GPIOIN, bus.IRQ_PEND, bus.GPIOINT, g, p, i);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  initial begin
    HRESET      = 1'b1;
    bus.PIN_IN  = 16'hFFFF;
    bus.RISE_EN = 16'h0000;
    bus.FALL_EN = 16'h0000;
    bus.IRQ_CLR = 16'h0000;

    // reset held two cycles with all pins high
    expect_at(1, "rst_a", 16'h0000, 16'h0000, 1'b0);
    expect_at(2, "rst_b", 16'h0000, 16'h0000, 1'b0);
    cycles(2);
    check_now("rst_state", 16'h0000, 16'h0000, 1'b0);
    HRESET = 1'b0;
    expect_at(1, "rel_first", 16'h0000, 16'h0000, 1'b0);
    expect_at(5, "hold_r4", 16'h0000, 16'h0000, 1'b0);
    expect_at(6, "hold_r5", 16'hFFFF, 16'h0000, 1'b0);
    cycles(6);
    bus.PIN_IN = 16'h0000;
    expect_at(6, "fall_quiet", 16'h0000, 16'h0000, 1'b0);
    cycles(6);

    // clean rise on bit 3
    bus.RISE_EN = 16'h0008;
    bus.PIN_IN  = 16'h0008;
    expect_at(5, "rise_e4", 16'h0000, 16'h0000, 1'b0);
    expect_at(6, "rise_e5", 16'h0008, 16'h0008, 1'b1);
    cycles(6);
    bus.IRQ_CLR = 16'h0008;
    expect_at(1, "rise_clr", 16'h0008, 16'h0000, 1'b0);
    cycles(1);
    bus.IRQ_CLR = 16'h0000;
    bus.PIN_IN  = 16'h0000;
    expect_at(6, "rise_back", 16'h0000, 16'h0000, 1'b0);
    cycles(6);
    bus.RISE_EN = 16'h0000;

    // 3-cycle glitch rejected, 4-cycle pulse accepted
    bus.RISE_EN = 16'h0001;
    bus.PIN_IN  = 16'h0001;
    cycles(3);
    bus.PIN_IN = 16'h0000;
    expect_at(8, "glitch", 16'h0000, 16'h0000, 1'b0);
    cycles(8);
    bus.PIN_IN = 16'h0001;
    cycles(4);
    bus.PIN_IN = 16'h0000;
    expect_at(2, "pulse4", 16'h0001, 16'h0001, 1'b1);
    expect_at(6, "pulse4_back", 16'h0000, 16'h0001, 1'b1);
    cycles(6);
    bus.IRQ_CLR = 16'h0001;
    expect_at(1, "pulse4_clr", 16'h0000, 16'h0000, 1'b0);
    cycles(1);
    bus.IRQ_CLR = 16'h0000;
    bus.RISE_EN = 16'h0000;

    // falling-edge only on bit 7
    bus.FALL_EN = 16'h0080;
    bus.PIN_IN  = 16'h0080;
    expect_at(6, "sel_rise", 16'h0080, 16'h0000, 1'b0);
    cycles(6);
    bus.PIN_IN = 16'h0000;
    expect_at(5, "sel_e4", 16'h0080, 16'h0000, 1'b0);
    expect_at(6, "sel_fall", 16'h0000, 16'h0080, 1'b1);
    cycles(6);

    // clear colliding with a new fall accept, then clear on the next cycle
    bus.PIN_IN = 16'h0080;
    expect_at(6, "col_rise", 16'h0080, 16'h0080, 1'b1);
    cycles(6);
    bus.PIN_IN = 16'h0000;
    cycles(5);
    bus.IRQ_CLR = 16'h0080;
    expect_at(1, "col_same", 16'h0000, 16'h0080, 1'b1);
    cycles(1);
    expect_at(1, "col_next", 16'h0000, 16'h0000, 1'b0);
    cycles(1);
    bus.IRQ_CLR = 16'h0000;
    bus.FALL_EN = 16'h0000;

    // simultaneous accepts on many bits; disabling enables keeps pending
    bus.RISE_EN = 16'hFFFF;
    bus.PIN_IN  = 16'hA5A5;
    expect_at(6, "multi", 16'hA5A5, 16'hA5A5, 1'b1);
    cycles(6);
    bus.RISE_EN = 16'h0000;
    expect_at(1, "en_off_sticky", 16'hA5A5, 16'hA5A5, 1'b1);
    cycles(1);
    bus.PIN_IN = 16'h0000;
    expect_at(6, "multi_back", 16'h0000, 16'hA5A5, 1'b1);
    cycles(6);
    bus.IRQ_CLR = 16'hFFFF;
    expect_at(1, "multi_clr", 16'h0000, 16'h0000, 1'b0);
    cycles(1);
    bus.IRQ_CLR = 16'h0000;

    // reset in the middle of a debounce count on bit 5
    bus.PIN_IN = 16'h0020;
    cycles(4);
    HRESET = 1'b1;
    expect_at(1, "mid_rst", 16'h0000, 16'h0000, 1'b0);
    cycles(1);
    HRESET = 1'b0;
    expect_at(5, "mid_r4", 16'h0000, 16'h0000, 1'b0);
    expect_at(6, "mid_r5", 16'h0020, 16'h0000, 1'b0);
    cycles(6);

    cycles(2);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $error("FAIL expired_wait: %0d expectation(s) never checked", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
